// File: rtl/tqvp_htfab_vga_fb.sv
// TinyQV VGA peripheral: configurable timing, 1/2-bpp register framebuffer,
// 4-entry RGB222 palette and an auto-incrementing indirect framebuffer port.
module tqvp_htfab_vga_fb #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29,
    parameter int SYNC_NEG = 1,
    parameter int COLS     = 32,
    parameter int ROWS     = 24,
    parameter int PIX_W    = 32,
    parameter int PIX_H    = 32,
    parameter int BPP      = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int FB_WORDS = COLS * ROWS * BPP / 32;
    localparam int AW = (FB_WORDS > 1) ? $clog2(FB_WORDS) : 1;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int CW = $clog2(COLS + 1);
    localparam int RW = $clog2(ROWS + 1);
    localparam int XW = (PIX_W > 1) ? $clog2(PIX_W) : 1;
    localparam int YW = (PIX_H > 1) ? $clog2(PIX_H) : 1;
    localparam int PW = $clog2(COLS * ROWS * BPP + 1);
    localparam logic SYNC_IDLE = (SYNC_NEG != 0);

    typedef enum logic [3:0] {
        REG_CTRL    = 4'h0,
        REG_STATUS  = 4'h1,
        REG_FB_ADDR = 4'h2,
        REG_FB_DATA = 4'h3,
        REG_PALETTE = 4'h4
    } reg_sel_e;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic [XW-1:0] px_cnt;
    logic [YW-1:0] py_cnt;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    logic [1:0]    ctrl;
    logic          pending;
    logic [7:0]    frame_cnt;
    logic [AW-1:0] fb_addr;
    logic [31:0]   palette;
    logic [31:0]   fb [FB_WORDS];

    logic h_wrap, v_wrap, h_act, v_act, hs_act, vs_act, frame_tick, in_vblank;
    assign h_wrap     = (h_cnt == HW'(H_TOTAL - 1));
    assign v_wrap     = (v_cnt == VW'(V_TOTAL - 1));
    assign h_act      = (h_cnt < HW'(H_ACTIVE));
    assign v_act      = (v_cnt < VW'(V_ACTIVE));
    assign hs_act     = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
    assign vs_act     = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));
    assign frame_tick = (h_cnt == '0) && (v_cnt == VW'(V_ACTIVE));
    assign in_vblank  = !v_act;

    logic unused_bits;
    assign unused_bits = &{1'b0, ui_in, address[1:0]};

    // col/row step through sub-counters so no divider is needed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt  <= '0;
            v_cnt  <= '0;
            px_cnt <= '0;
            py_cnt <= '0;
            col    <= '0;
            row    <= '0;
        end else if (h_wrap) begin
            h_cnt  <= '0;
            px_cnt <= '0;
            col    <= '0;
            if (v_wrap) begin
                v_cnt  <= '0;
                py_cnt <= '0;
                row    <= '0;
            end else begin
                v_cnt <= v_cnt + 1'b1;
                if (v_act) begin
                    if (py_cnt == YW'(PIX_H - 1)) begin
                        py_cnt <= '0;
                        row    <= row + 1'b1;
                    end else begin
                        py_cnt <= py_cnt + 1'b1;
                    end
                end
            end
        end else begin
            h_cnt <= h_cnt + 1'b1;
            if (h_act) begin
                if (px_cnt == XW'(PIX_W - 1)) begin
                    px_cnt <= '0;
                    col    <= col + 1'b1;
                end else begin
                    px_cnt <= px_cnt + 1'b1;
                end
            end
        end
    end

    logic [PW-1:0] pix_bit;
    logic [31:0]   pix_word;
    logic [1:0]    pal_idx;
    logic [5:0]    colour, rgb;
    logic          hs_lvl, vs_lvl;

    assign pix_bit  = PW'(row) * PW'(COLS * BPP) + PW'(col) * PW'(BPP);
    assign pix_word = fb[AW'(pix_bit[PW-1:5])];

    always_comb begin
        pal_idx = '0;
        pal_idx[BPP-1:0] = pix_word[pix_bit[4:0] +: BPP];
    end

    assign colour = palette[{pal_idx, 3'b000} +: 6];
    assign rgb    = (h_act && v_act && ctrl[0]) ? colour : '0;
    assign hs_lvl = hs_act ^ SYNC_IDLE;
    assign vs_lvl = vs_act ^ SYNC_IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            uo_out <= {SYNC_IDLE, 3'b000, SYNC_IDLE, 3'b000};
        end else begin
            uo_out <= {hs_lvl, rgb[0], rgb[2], rgb[4], vs_lvl, rgb[1], rgb[3], rgb[5]};
        end
    end

    logic          wr_en, rd_en, fb_wr;
    logic [31:0]   wmask, rd_val;
    logic [AW-1:0] fb_addr_next;

    assign wr_en        = (data_write_n != 2'b11);
    assign rd_en        = (data_read_n != 2'b11) && !data_ready;
    assign fb_wr        = (data_write_n == 2'b10) && (address[5:2] == REG_FB_DATA);
    assign fb_addr_next = (fb_addr == AW'(FB_WORDS - 1)) ? '0 : fb_addr + 1'b1;

    always_comb begin
        case (data_write_n)
            2'b00:   wmask = 32'h0000_00FF;
            2'b01:   wmask = 32'h0000_FFFF;
            default: wmask = 32'hFFFF_FFFF;
        endcase
    end

    always_comb begin
        rd_val = '0;
        case (address[5:2])
            REG_CTRL:    rd_val = {30'b0, ctrl};
            REG_STATUS:  rd_val = {16'b0, frame_cnt, 6'b0, in_vblank, pending};
            REG_FB_ADDR: rd_val = 32'(fb_addr);
            REG_FB_DATA: rd_val = fb[fb_addr];
            REG_PALETTE: rd_val = palette;
            default:     rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl       <= '0;
            pending    <= 1'b0;
            frame_cnt  <= '0;
            fb_addr    <= '0;
            palette    <= '0;
            data_ready <= 1'b0;
            data_out   <= '0;
        end else begin
            data_ready <= rd_en;
            data_out   <= rd_en ? rd_val : '0;

            // a frame tick wins over a simultaneous write-1-to-clear
            if (frame_tick) begin
                pending   <= 1'b1;
                frame_cnt <= frame_cnt + 1'b1;
            end else if (wr_en && (address[5:2] == REG_STATUS) && data_in[0]) begin
                pending <= 1'b0;
            end

            if (wr_en) begin
                case (address[5:2])
                    REG_CTRL:    ctrl <= data_in[1:0];
                    REG_FB_ADDR: fb_addr <= (FB_WORDS == 1) ? '0 :
                                     AW'((32'(fb_addr) & ~wmask) | (data_in & wmask));
                    REG_FB_DATA: if (fb_wr) fb_addr <= fb_addr_next;
                    REG_PALETTE: palette <= (palette & ~wmask) | (data_in & wmask);
                    default: ;
                endcase
            end

            if (rd_en && (address[5:2] == REG_FB_DATA)) begin
                fb_addr <= fb_addr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && fb_wr) begin
            fb[fb_addr] <= data_in;
        end
    end

    assign user_interrupt = pending & ctrl[1];

endmodule
